memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares one single-port memory core between NUM_REQ independent system-side requesters.
- Grants are round-robin.
- Drives the core's we_mem/ce_mem/addr_mem/datai_mem and samples datao_mem.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Sits between the testcase/system masters and the memory core. Replaces the single-master controller when more than one master needs the memory.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester command valid (cmd_valid_sys per port).
- req_we  input  NUM_REQ  per-requester write enable: 1 = write, 0 = read.
- req_addr  input  NUM_REQ x ADDR_W  per-requester address, packed 2-D.
- req_wdata  input  NUM_REQ x DATA_W  per-requester write data, packed 2-D.
- req_ready  output  NUM_REQ  one-hot, one-cycle completion pulse.
- req_rdata  output  DATA_W  read data, valid while the granted bit of req_ready is 1.
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  output  1  high while not in IDLE.
- we_mem  output  1  core write enable.
- ce_mem  output  1  core chip enable.
- addr_mem  output  ADDR_W  core address.
- datai_mem  output  DATA_W  core write data.
- datao_mem  input  DATA_W  core read data, valid one cycle after a read access.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, priority pointer=0.
  - All outputs 0: we_mem, ce_mem, addr_mem, datai_mem, req_ready, req_rdata, grant_id, busy.
  - Reset overrides any in-flight transaction. An aborted requester receives no ready; it must re-issue.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req_valid is set, choose the first set bit scanning from the pointer upward, wrapping modulo NUM_REQ.
  - Latch that requester's we/addr/wdata into registers and set grant_id.
  - Pointer <= (granted+1) mod NUM_REQ.
  - Registered outputs for the next cycle: ce_mem=1, we_mem=latched we, addr_mem/datai_mem=latched values.
  - Go to ACCESS, busy=1.
  - If no req_valid is set, stay in IDLE with outputs idle.
- ACCESS:
  - The core sees exactly one cycle of ce_mem=1.
  - Next state DONE. At this edge ce_mem<=0 and we_mem<=0; addr_mem and datai_mem hold their values.
- DONE:
  - req_ready[grant_id]=1 for exactly this cycle.
  - For a read, req_rdata <= datao_mem sampled at the ACCESS->DONE edge.
  - For a write, req_rdata holds its previous value.
  - Next state IDLE; busy=0 in IDLE.
- Latency: request first seen in IDLE at cycle N gives ce_mem high at N+1 and req_ready at N+2. Throughput is one transaction per 3 cycles.
- Requester rules:
  - Hold req_valid until ready is seen.
  - Drop req_valid, or present a new command, on the cycle after ready.
  - Fields are latched at grant, so changes after grant do not affect the access in flight.
- Requests arriving during ACCESS or DONE wait. They are arbitrated only in IDLE.
- Simultaneous requests: strict round-robin from the pointer. With all NUM_REQ requesting, each is served once before any is served twice.
- Pointer wrap: NUM_REQ-1 granted sets pointer=0.
- req_valid deasserted after grant (protocol violation): the transaction still completes and ready is still pulsed.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  - default width localparams ADDR_W_DEF=8, DATA_W_DEF=8.
- Sub-module rr_priority_select: combinational. Inputs are the request vector and pointer. Outputs are found and grant index.
- The FSM and datapath registers live in memory_arbiter.

Test Plan:
- Single write: req 0 writes addr 8'h10, data 8'hA5 -> ce_mem=1, we_mem=1, addr_mem=8'h10, datai_mem=8'hA5 for exactly one cycle; req_ready=2'b01 two cycles after valid.
- Single read: req 1 reads 8'h10 after the previous write, core model returns 8'hA5 -> req_ready=2'b10 with req_rdata=8'hA5 at cycle N+2; we_mem stays 0.
- Contention: req 0 and req 1 both valid from reset, pointer=0, each holding valid and re-requesting immediately for six transactions -> grant order 0,1,0,1,0,1; no ready is ever on two bits.
- Wrap with NUM_REQ=3: all three valid continuously -> grant_id sequence 0,1,2,0,1,2; pointer returns to 0 after 2.
- Reset mid-operation: assert reset low during ACCESS of a write to 8'h20 -> next cycle all outputs 0, no req_ready pulse, state IDLE; after release, the re-issued request completes normally.
- Late arrival: req 1 asserts valid during req 0's ACCESS cycle -> req 1 is not granted until the IDLE cycle after req 0's DONE; ce_mem shows two separate one-cycle pulses three cycles apart.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the multi-requester memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   // Rotating scan index: (base + offs) mod n, with base < n and offs < n.
   function automatic int wrap_idx(input int base, input int offs, input int n);
      int sum;
      sum = base + offs;
      return (sum >= n) ? sum - n : sum;
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester-side command/response bundle shared by all masters of the arbiter.
interface memory_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]             req_ready;
   logic [DATA_W-1:0]              req_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, req_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, req_rdata
   );
endinterface

// File: rtl/memory_arbiter_rr_priority_select.sv
// Round-robin pick: first set request at or above the pointer, wrapping.
module rr_priority_select
   import mem_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   grant
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      found = 1'b0;
      grant = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'(wrap_idx(int'(ptr), i, NUM_REQ));
         if (!found && req[cand]) begin
            found = 1'b1;
            grant = cand;
         end
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory core among NUM_REQ requesters.
//
// state  | meaning
// IDLE   | arbitrate pending requests, latch winner's command
// ACCESS | core sees one cycle of ce_mem for the latched command
// DONE   | one-cycle ready pulse to the granted requester
module memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   parameter  int ADDR_W  = ADDR_W_DEF,
   parameter  int DATA_W  = DATA_W_DEF,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              reset,
   memory_arbiter_if.slave   req_bus,
   output logic [IDX_W-1:0]  grant_id,
   output logic              busy,
   output logic              we_mem,
   output logic              ce_mem,
   output logic [ADDR_W-1:0] addr_mem,
   output logic [DATA_W-1:0] datai_mem,
   input  logic [DATA_W-1:0] datao_mem
);

   arb_state_t         state;
   logic [IDX_W-1:0]   ptr;
   logic               lat_we;
   logic               found;
   logic [IDX_W-1:0]   sel_idx;
   logic [NUM_REQ-1:0] ready_q;
   logic [DATA_W-1:0]  rdata_q;

   assign req_bus.req_ready = ready_q;
   assign req_bus.req_rdata = rdata_q;

   rr_priority_select #(.NUM_REQ(NUM_REQ)) u_sel (
      .req   (req_bus.req_valid),
      .ptr   (ptr),
      .found (found),
      .grant (sel_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= '0;
         lat_we    <= 1'b0;
         grant_id  <= '0;
         busy      <= 1'b0;
         we_mem    <= 1'b0;
         ce_mem    <= 1'b0;
         addr_mem  <= '0;
         datai_mem <= '0;
         ready_q   <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               ready_q <= '0;
               if (found) begin
                  grant_id  <= sel_idx;
                  ptr       <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                  lat_we    <= req_bus.req_we[sel_idx];
                  ce_mem    <= 1'b1;
                  we_mem    <= req_bus.req_we[sel_idx];
                  addr_mem  <= req_bus.req_addr[sel_idx];
                  datai_mem <= req_bus.req_wdata[sel_idx];
                  busy      <= 1'b1;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // addr_mem/datai_mem stay put so the core output remains stable into DONE
               ce_mem            <= 1'b0;
               we_mem            <= 1'b0;
               ready_q           <= '0;
               ready_q[grant_id] <= 1'b1;
               if (!lat_we) begin
                  rdata_q <= datao_mem;
               end
               state <= DONE;
            end
            DONE: begin
               ready_q <= '0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: scoreboarded 2-requester instance plus a 3-requester wrap instance.
module tb_memory_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 8;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   // two-requester instance with a behavioural core
   memory_arbiter_if #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) bus2 ();
   logic [0:0]    grant_id2;
   logic          busy2, we_mem2, ce_mem2;
   logic [AW-1:0] addr_mem2;
   logic [DW-1:0] datai_mem2, datao_mem2;

   memory_arbiter #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW)) dut2 (
      .clk       (clk),
      .reset     (reset),
      .req_bus   (bus2),
      .grant_id  (grant_id2),
      .busy      (busy2),
      .we_mem    (we_mem2),
      .ce_mem    (ce_mem2),
      .addr_mem  (addr_mem2),
      .datai_mem (datai_mem2),
      .datao_mem (datao_mem2)
   );

   logic [DW-1:0] core_mem [0:255];
   assign datao_mem2 = core_mem[addr_mem2];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) core_mem[i] <= '0;
      end else if (ce_mem2 && we_mem2) begin
         core_mem[addr_mem2] <= datai_mem2;
      end
   end

   // three-requester instance for pointer wrap
   memory_arbiter_if #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) bus3 ();
   logic [1:0]    grant_id3;
   logic          busy3, we_mem3, ce_mem3;
   logic [AW-1:0] addr_mem3;
   logic [DW-1:0] datai_mem3;
   logic [DW-1:0] datao_mem3;
   assign datao_mem3 = 8'h3C;

   memory_arbiter #(.NUM_REQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
      .clk       (clk),
      .reset     (reset),
      .req_bus   (bus3),
      .grant_id  (grant_id3),
      .busy      (busy3),
      .we_mem    (we_mem3),
      .ce_mem    (ce_mem3),
      .addr_mem  (addr_mem3),
      .datai_mem (datai_mem3),
      .datao_mem (datao_mem3)
   );

   typedef struct {
      int         idx;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } exp_t;

   exp_t       sb[$];
   int         ce_starts[$];
   logic [7:0] model_mem [0:255];
   logic [7:0] model_rdata;
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_done = 0;
   int         cyc = 0;
   logic       ce_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic we, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.idx = idx; e.we = we; e.addr = a; e.wdata = d;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [0:0] r, input logic we, input logic [7:0] a, input logic [7:0] d);
      bus2.req_valid[r] = 1'b1;
      bus2.req_we[r]    = we;
      bus2.req_addr[r]  = a;
      bus2.req_wdata[r] = d;
   endtask

   // advance one clock, then check core access and ready against the scoreboard
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (ce_mem2) begin
         chk("ce_has_cmd", 32'(sb.size() > 0), 32'd1);
         chk("ce_single_cycle", 32'(ce_prev), 32'd0);
         if (sb.size() > 0) begin
            chk("ce_grant_id", 32'(grant_id2), 32'(sb[0].idx));
            chk("ce_we_mem", 32'(we_mem2), 32'(sb[0].we));
            chk("ce_addr_mem", 32'(addr_mem2), 32'(sb[0].addr));
            if (sb[0].we) chk("ce_datai_mem", 32'(datai_mem2), 32'(sb[0].wdata));
         end
         if (!ce_prev) ce_starts.push_back(cyc);
      end
      chk("ready_onehot0", 32'($onehot0(bus2.req_ready)), 32'd1);
      if (|bus2.req_ready) begin
         chk("ready_has_cmd", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.we) model_mem[e.addr] = e.wdata;
            else      model_rdata = model_mem[e.addr];
            chk("ready_vec", 32'(bus2.req_ready), 32'd1 << e.idx);
            chk("ready_grant_id", 32'(grant_id2), 32'(e.idx));
            chk("ready_rdata", 32'(bus2.req_rdata), 32'(model_rdata));
         end
         n_done++;
      end
      ce_prev = ce_mem2;
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && n_done < target; i++) cycle();
      chk(tag, 32'(n_done >= target), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_we"},    32'(we_mem2),        32'd0);
      chk({tag, "_ce"},    32'(ce_mem2),        32'd0);
      chk({tag, "_addr"},  32'(addr_mem2),      32'd0);
      chk({tag, "_datai"}, 32'(datai_mem2),     32'd0);
      chk({tag, "_ready"}, 32'(bus2.req_ready), 32'd0);
      chk({tag, "_rdata"}, 32'(bus2.req_rdata), 32'd0);
      chk({tag, "_gid"},   32'(grant_id2),      32'd0);
      chk({tag, "_busy"},  32'(busy2),          32'd0);
   endtask

   initial begin
      bus2.req_valid = '0; bus2.req_we = '0; bus2.req_addr = '0; bus2.req_wdata = '0;
      bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
      for (int i = 0; i < 256; i++) model_mem[i] = '0;
      model_rdata = '0;

      // reset state
      cycle(); cycle();
      check_idle_outputs("reset");
      chk("reset_busy3", 32'(busy3), 32'd0);
      reset = 1'b1; mem_clr = 1'b0;
      cycle();

      // single write from requester 0
      drive(1'b0, 1'b1, 8'h10, 8'hA5);
      push(0, 1'b1, 8'h10, 8'hA5);
      cycle();
      chk("wr_ce_n1", 32'(ce_mem2), 32'd1);
      chk("wr_busy_n1", 32'(busy2), 32'd1);
      cycle();
      chk("wr_ready_n2", 32'(bus2.req_ready), 32'd1);
      chk("wr_ce_off_n2", 32'(ce_mem2), 32'd0);
      chk("wr_addr_hold", 32'(addr_mem2), 32'h10);
      bus2.req_valid = '0;
      cycle();
      chk("wr_busy_idle", 32'(busy2), 32'd0);
      chk("wr_ready_idle", 32'(bus2.req_ready), 32'd0);

      // single read from requester 1
      drive(1'b1, 1'b0, 8'h10, 8'h00);
      push(1, 1'b0, 8'h10, 8'h00);
      cycle();
      chk("rd_ce_n1", 32'(ce_mem2), 32'd1);
      chk("rd_we_low", 32'(we_mem2), 32'd0);
      cycle();
      chk("rd_ready_n2", 32'(bus2.req_ready), 32'd2);
      chk("rd_rdata", 32'(bus2.req_rdata), 32'hA5);
      bus2.req_valid = '0;
      cycle();

      // contention from a fresh reset: strict alternation with both requesters held valid
      reset = 1'b0; cycle(); reset = 1'b1; model_rdata = '0; cycle();
      drive(1'b0, 1'b1, 8'h30, 8'h5A);
      drive(1'b1, 1'b0, 8'h30, 8'h00);
      for (int k = 0; k < 6; k++) push(k % 2, (k % 2) == 0, 8'h30, 8'h5A);
      wait_done("contention_done", n_done + 6, 40);
      bus2.req_valid = '0;
      cycle(); cycle();
      chk("contention_sb_empty", 32'(sb.size()), 32'd0);
      chk("contention_idle_busy", 32'(busy2), 32'd0);

      // reset during ACCESS aborts the write; the re-issued request completes
      drive(1'b0, 1'b1, 8'h20, 8'h77);
      push(0, 1'b1, 8'h20, 8'h77);
      cycle();
      chk("abort_in_access", 32'(ce_mem2), 32'd1);
      reset = 1'b0;
      sb.delete();
      cycle();
      model_rdata = '0;
      check_idle_outputs("abort");
      reset = 1'b1;
      push(0, 1'b1, 8'h20, 8'h77);
      wait_done("reissue_done", n_done + 1, 10);
      bus2.req_valid = '0;
      cycle();

      // late arrival: requester 1 shows up during requester 0's ACCESS
      ce_starts.delete();
      drive(1'b0, 1'b1, 8'h40, 8'h99);
      push(0, 1'b1, 8'h40, 8'h99);
      cycle();
      drive(1'b1, 1'b0, 8'h20, 8'h00);
      push(1, 1'b0, 8'h20, 8'h00);
      wait_done("late_first_done", n_done + 1, 10);
      bus2.req_valid[0] = 1'b0;
      wait_done("late_second_done", n_done + 1, 10);
      bus2.req_valid = '0;
      cycle();
      chk("late_ce_count", 32'(ce_starts.size()), 32'd2);
      if (ce_starts.size() == 2) chk("late_ce_gap", 32'(ce_starts[1] - ce_starts[0]), 32'd3);
      chk("late_rdata", 32'(bus2.req_rdata), 32'h77);

      // three requesters continuously valid: grant order wraps 0,1,2,0,1,2
      bus3.req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         int j;
         j = 0;
         cycle();
         while (!(|bus3.req_ready) && j < 8) begin
            cycle();
            j++;
         end
         chk("wrap_seen", 32'(|bus3.req_ready), 32'd1);
         chk("wrap_gid", 32'(grant_id3), 32'(k % 3));
         chk("wrap_ready", 32'(bus3.req_ready), 32'd1 << (k % 3));
         chk("wrap_rdata", 32'(bus3.req_rdata), 32'h3C);
      end
      bus3.req_valid = '0;
      cycle(); cycle();
      chk("wrap_idle_busy", 32'(busy3), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
